// File: rtl/ws2812_rx.sv
// rtl/ws2812_rx.sv - WS2812 single-wire stream decoder producing 24-bit per-LED words
module ws2812_rx #(
    parameter int NUM_LEDS     = 24,
    parameter int BIT_THRESH   = 7,
    parameter int MIN_HIGH     = 2,
    parameter int MAX_HIGH     = 24,
    parameter int RESET_CYCLES = 600
) (
    input  logic        hwclk,
    input  logic        reset,
    input  logic        ws_din,
    output logic [23:0] rgb_data,
    output logic [7:0]  led_num,
    output logic        rgb_valid,
    output logic        frame_done,
    output logic [7:0]  led_count,
    output logic        bit_err,
    output logic        overflow
);
    localparam int CW = $clog2(RESET_CYCLES + 1);
    localparam logic [CW-1:0] RC_C  = CW'(RESET_CYCLES);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_HIGH);
    localparam logic [CW-1:0] MIN_C = CW'(MIN_HIGH);
    localparam logic [CW-1:0] TH_C  = CW'(BIT_THRESH);
    localparam logic [CW-1:0] ONE_C = CW'(1);
    localparam logic [7:0]    NL_C  = 8'(NUM_LEDS);

    typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;

    logic          s1_q, s2_q, s3_q;
    state_t        state_q, state_d;
    logic [CW-1:0] hcnt_q, hcnt_d, lcnt_q, lcnt_d;
    logic [23:0]   shift_q, shift_d;
    logic [4:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    idx_q, idx_d;
    logic          word_pend_q, word_pend_d;
    logic [23:0]   rgb_data_q, rgb_data_d;
    logic [7:0]    led_num_q, led_num_d;
    logic          rgb_valid_q, rgb_valid_d;
    logic          frame_done_q, frame_done_d;
    logic [7:0]    led_count_q, led_count_d;
    logic          bit_err_q, bit_err_d;
    logic          overflow_q, overflow_d;

    logic          rise, fall;
    logic [CW-1:0] hcnt_inc, lcnt_inc;

    assign rise     = s2_q & ~s3_q;
    assign fall     = ~s2_q & s3_q;
    assign hcnt_inc = (hcnt_q == '1) ? hcnt_q : hcnt_q + ONE_C;
    assign lcnt_inc = (lcnt_q >= RC_C) ? lcnt_q : lcnt_q + ONE_C;

    always_comb begin
        state_d      = state_q;
        hcnt_d       = hcnt_q;
        lcnt_d       = lcnt_q;
        shift_d      = shift_q;
        bitcnt_d     = bitcnt_q;
        idx_d        = idx_q;
        word_pend_d  = 1'b0;
        rgb_data_d   = rgb_data_q;
        led_num_d    = led_num_q;
        rgb_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        led_count_d  = led_count_q;
        bit_err_d    = 1'b0;
        overflow_d   = overflow_q;

        // A word completed on the previous sample is published one cycle later
        if (word_pend_q) begin
            if (idx_q < NL_C) begin
                rgb_data_d  = shift_q;
                led_num_d   = idx_q;
                rgb_valid_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
            if (idx_q != 8'hFF) begin
                idx_d = idx_q + 8'd1;
            end
        end

        unique case (state_q)
            SYNC: begin
                if (s2_q) begin
                    lcnt_d = '0;
                end else if (lcnt_inc == RC_C) begin
                    lcnt_d  = '0;
                    state_d = IDLE;
                end else begin
                    lcnt_d = lcnt_inc;
                end
            end
            IDLE: begin
                if (rise) begin
                    state_d    = HIGH;
                    hcnt_d     = ONE_C;
                    overflow_d = 1'b0;
                end
            end
            HIGH: begin
                if (fall) begin
                    if (hcnt_q < MIN_C) begin
                        bit_err_d = 1'b1;
                    end else begin
                        shift_d = {shift_q[22:0], (hcnt_q >= TH_C)};
                        if (bitcnt_q == 5'd23) begin
                            bitcnt_d    = 5'd0;
                            word_pend_d = 1'b1;
                        end else begin
                            bitcnt_d = bitcnt_q + 5'd1;
                        end
                    end
                    state_d = LOW;
                    lcnt_d  = ONE_C;
                end else if (hcnt_inc > MAX_C) begin
                    // Stuck-high line: drop the frame and wait for a clean latch gap
                    bit_err_d = 1'b1;
                    state_d   = SYNC;
                    lcnt_d    = '0;
                    hcnt_d    = '0;
                    bitcnt_d  = 5'd0;
                    idx_d     = 8'd0;
                    shift_d   = '0;
                end else begin
                    hcnt_d = hcnt_inc;
                end
            end
            LOW: begin
                // Frame end outranks a coincident rising edge, which then opens the next frame
                if (lcnt_q == RC_C) begin
                    frame_done_d = 1'b1;
                    led_count_d  = (idx_q > NL_C) ? NL_C : idx_q;
                    bit_err_d    = (bitcnt_q != 5'd0);
                    bitcnt_d     = 5'd0;
                    idx_d        = 8'd0;
                    shift_d      = '0;
                    lcnt_d       = '0;
                    if (rise) begin
                        state_d    = HIGH;
                        hcnt_d     = ONE_C;
                        overflow_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (rise) begin
                    state_d = HIGH;
                    hcnt_d  = ONE_C;
                end else begin
                    lcnt_d = lcnt_inc;
                end
            end
            default: state_d = SYNC;
        endcase
    end

    always_ff @(posedge hwclk) begin
        if (!reset) begin
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            s3_q         <= 1'b0;
            state_q      <= SYNC;
            hcnt_q       <= '0;
            lcnt_q       <= '0;
            shift_q      <= '0;
            bitcnt_q     <= 5'd0;
            idx_q        <= 8'd0;
            word_pend_q  <= 1'b0;
            rgb_data_q   <= '0;
            led_num_q    <= 8'd0;
            rgb_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            led_count_q  <= 8'd0;
            bit_err_q    <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            s1_q         <= ws_din;
            s2_q         <= s1_q;
            s3_q         <= s2_q;
            state_q      <= state_d;
            hcnt_q       <= hcnt_d;
            lcnt_q       <= lcnt_d;
            shift_q      <= shift_d;
            bitcnt_q     <= bitcnt_d;
            idx_q        <= idx_d;
            word_pend_q  <= word_pend_d;
            rgb_data_q   <= rgb_data_d;
            led_num_q    <= led_num_d;
            rgb_valid_q  <= rgb_valid_d;
            frame_done_q <= frame_done_d;
            led_count_q  <= led_count_d;
            bit_err_q    <= bit_err_d;
            overflow_q   <= overflow_d;
        end
    end

    assign rgb_data   = rgb_data_q;
    assign led_num    = led_num_q;
    assign rgb_valid  = rgb_valid_q;
    assign frame_done = frame_done_q;
    assign led_count  = led_count_q;
    assign bit_err    = bit_err_q;
    assign overflow   = overflow_q;
endmodule

// File: tb/tb_ws2812_rx.sv
// tb/tb_ws2812_rx.sv - scoreboard bench for ws2812_rx
module tb_ws2812_rx;
    logic        hwclk = 1'b0;
    logic        reset;
    logic        ws_din;
    logic [23:0] rgb_data;
    logic [7:0]  led_num;
    logic        rgb_valid;
    logic        frame_done;
    logic [7:0]  led_count;
    logic        bit_err;
    logic        overflow;

    always #5 hwclk = ~hwclk;

    ws2812_rx dut (
        .hwclk      (hwclk),
        .reset      (reset),
        .ws_din     (ws_din),
        .rgb_data   (rgb_data),
        .led_num    (led_num),
        .rgb_valid  (rgb_valid),
        .frame_done (frame_done),
        .led_count  (led_count),
        .bit_err    (bit_err),
        .overflow   (overflow)
    );

    typedef struct packed {
        logic [23:0] data;
        logic [7:0]  num;
    } word_t;
    typedef struct packed {
        logic [7:0] count;
        logic       err;
    } frame_t;

    word_t  wq[$];
    frame_t fq[$];
    int n_total  = 0;
    int n_pass   = 0;
    int berr_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic expect_word(input logic [23:0] d, input int n);
        word_t w;
        w.data = d;
        w.num  = 8'(n);
        wq.push_back(w);
    endtask

    task automatic expect_frame(input int cnt, input logic err);
        frame_t f;
        f.count = 8'(cnt);
        f.err   = err;
        fq.push_back(f);
    endtask

    task automatic drive(input logic v, input int n);
        ws_din = v;
        repeat (n) @(posedge hwclk);
        #1;
    endtask

    task automatic send_range(input logic [23:0] w, input int msb, input int lsb, input int last_low);
        for (int i = msb; i >= lsb; i--) begin
            drive(1'b1, w[i] ? 9 : 4);
            drive(1'b0, (i == lsb && last_low > 0) ? last_low : (w[i] ? 6 : 11));
        end
    endtask

    // Monitor: every strobe is matched against the scoreboard queues
    always @(negedge hwclk) begin
        word_t  ew;
        frame_t ef;
        if (reset === 1'b1) begin
            if (rgb_valid) begin
                chk("rgb_valid_expected", 32'(wq.size() != 0), 32'd1);
                if (wq.size() != 0) begin
                    ew = wq.pop_front();
                    chk("rgb_data", 32'(rgb_data), 32'(ew.data));
                    chk("led_num", 32'(led_num), 32'(ew.num));
                end
            end
            if (frame_done) begin
                chk("frame_done_expected", 32'(fq.size() != 0), 32'd1);
                if (fq.size() != 0) begin
                    ef = fq.pop_front();
                    chk("led_count", 32'(led_count), 32'(ef.count));
                    chk("frame_bit_err", 32'(bit_err), 32'(ef.err));
                end
            end else if (bit_err) begin
                berr_cnt++;
            end
        end
    end

    initial begin
        logic [23:0] mask;
        logic [23:0] d;
        int b0;

        reset  = 1'b0;
        ws_din = 1'b0;
        repeat (3) @(posedge hwclk);
        #1;
        chk("rst_rgb_data", 32'(rgb_data), 32'd0);
        chk("rst_led_num", 32'(led_num), 32'd0);
        chk("rst_strobes", 32'({rgb_valid, frame_done, bit_err}), 32'd0);
        chk("rst_led_count", 32'(led_count), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        reset = 1'b1;
        drive(1'b0, 610);

        // Single word with latency check on the final falling edge
        expect_word(24'hFF0000, 0);
        expect_frame(1, 1'b0);
        send_range(24'hFF0000, 23, 1, 0);
        drive(1'b1, 4);
        ws_din = 1'b0;
        repeat (3) @(posedge hwclk);
        #1;
        chk("latency_edge3", 32'(rgb_valid), 32'd0);
        @(posedge hwclk);
        #1;
        chk("latency_edge4", 32'(rgb_valid), 32'd1);
        drive(1'b0, 620);
        chk("t1_led_count", 32'(led_count), 32'd1);

        // Binary-clock frame 12:34:56
        mask = {8'd12, 8'd34, 8'd56};
        expect_frame(24, 1'b0);
        for (int i = 0; i < 24; i++) begin
            d = mask[23 - i] ? 24'h101010 : 24'h000000;
            expect_word(d, i);
            send_range(d, 23, 0, 0);
        end
        drive(1'b0, 620);
        chk("t2_led_count", 32'(led_count), 32'd24);

        // Width boundaries: 6 -> 0, 7 -> 1, 1 -> glitch, then 22 bits of 0x155555
        b0 = berr_cnt;
        expect_word(24'h555555, 0);
        drive(1'b1, 6); drive(1'b0, 11);
        drive(1'b1, 7); drive(1'b0, 11);
        drive(1'b1, 1); drive(1'b0, 11);
        send_range(24'h555555, 21, 0, 0);
        chk("glitch_bit_err", 32'(berr_cnt - b0), 32'd1);
        drive(1'b1, 25);
        drive(1'b0, 631);
        chk("overlong_bit_err", 32'(berr_cnt - b0), 32'd2);
        chk("overlong_no_frame", 32'(led_count), 32'd24);
        expect_word(24'h123456, 0);
        expect_frame(1, 1'b0);
        send_range(24'h123456, 23, 0, 0);
        drive(1'b0, 620);
        chk("t3_led_count", 32'(led_count), 32'd1);

        // 30 words into a 24-LED frame
        expect_frame(24, 1'b0);
        for (int i = 0; i < 30; i++) begin
            d = {8'(i), ~8'(i), 8'(i + 1)};
            if (i < 24) expect_word(d, i);
            send_range(d, 23, 0, 0);
            if (i == 23) chk("overflow_word24", 32'(overflow), 32'd0);
            if (i == 24) chk("overflow_word25", 32'(overflow), 32'd1);
        end
        drive(1'b0, 620);
        chk("t4_led_count", 32'(led_count), 32'd24);
        chk("overflow_held", 32'(overflow), 32'd1);
        expect_word(24'hA5C3E1, 0);
        expect_frame(1, 1'b0);
        drive(1'b1, 5);
        chk("overflow_cleared", 32'(overflow), 32'd0);
        drive(1'b1, 4);
        drive(1'b0, 6);
        send_range(24'hA5C3E1, 22, 0, 0);
        drive(1'b0, 620);

        // Partial word at frame end
        expect_frame(0, 1'b1);
        send_range(24'hABC000, 23, 12, 0);
        drive(1'b0, 620);
        chk("t5_led_count", 32'(led_count), 32'd0);

        // Gap 599 keeps the frame, gap 600 ends it as the next edge arrives
        expect_word(24'h0F0F0F, 0);
        expect_word(24'hF00F00, 1);
        expect_frame(2, 1'b0);
        expect_word(24'h3C3C3C, 0);
        send_range(24'h0F0F0F, 23, 0, 599);
        send_range(24'hF00F00, 23, 0, 600);
        send_range(24'h3C3C3C, 23, 0, 0);
        chk("t6_led_count", 32'(led_count), 32'd2);
        chk("t6_rgb_data", 32'(rgb_data), 32'h3C3C3C);

        // Reset mid-word
        send_range(24'hF0F0F0, 23, 14, 0);
        drive(1'b1, 3);
        reset = 1'b0;
        @(posedge hwclk);
        #1;
        chk("midrst_rgb_data", 32'(rgb_data), 32'd0);
        chk("midrst_led_count", 32'(led_count), 32'd0);
        chk("midrst_strobes", 32'({rgb_valid, frame_done, bit_err, overflow}), 32'd0);
        ws_din = 1'b0;
        repeat (2) @(posedge hwclk);
        #1;
        reset = 1'b1;
        drive(1'b0, 700);

        chk("words_left", 32'(wq.size()), 32'd0);
        chk("frames_left", 32'(fq.size()), 32'd0);
        chk("bit_err_total", 32'(berr_cnt), 32'd2);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
